controller: RTL
===============

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 WAIT_MAX, default 15, max consecutive memReady-low cycles tolerated in FETCH or MEM before abort.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 instruction  input  16  fetched word; [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc, [7:0] imm.
REQ-005 memReady  input  1  memory completes current read/write this cycle.
REQ-006 aluControl  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 PASSB.
REQ-007 pcRegEn  output  1  load PC register.
REQ-008 srcRegEn  output  1  load source-index register.
REQ-009 dstRegEn  output  1  load destination-index register.
REQ-010 immRegEn  output  1  load immediate register.
REQ-011 resultRegEn  output  1  load result register.
REQ-012 regFileEn  output  1  register-file write enable.
REQ-013 signEn  output  1  1 sign-extend, 0 zero-extend immediate.
REQ-014 pcRegMuxEn  output  1  ALU A operand: 0 PC, 1 regOut1.
REQ-015 mux4En  output  2  ALU B operand: 0 regOut2, 1 extended imm, 2 const 1, 3 const 0.
REQ-016 shiftALUMuxEn  output  1  0 ALU result, 1 shifter result.
REQ-017 regImmMuxEn  output  1  shift amount: 0 register, 1 immediate.
REQ-018 regFileResultCont  output  2  write-data select: 0 result register, 1 memdata.
REQ-019 memRead  output  1  memory read request.
REQ-020 memWrite  output  1  memory write request.
REQ-021 memErr  output  1  sticky memory-timeout flag.
REQ-022 state  output  3  current state encoding (debug).

Function
REQ-023 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable, decode to FETCH next cycle.
REQ-024 Every control output SHALL be 0 in any cycle/state not explicitly asserting it.
REQ-025 FETCH: memRead=1 until memReady; on memReady cycle latch instruction into internal IR, assert pcRegEn with pcRegMuxEn=0, mux4En=2, aluControl=ADD, shiftALUMuxEn=0 (PC+1), go DECODE.
REQ-026 DECODE: srcRegEn=dstRegEn=immRegEn=1; legal ALU/shift -> EXEC, LOAD/STOR -> MEM, illegal -> FETCH with no register-file or memory write.
REQ-027 Decode set S: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101; op=0000 with ext in S is register form; op in S is immediate form.
REQ-028 Shifts: op 1000 ext 0100 LSH (register amount), op 1000 ext 0000 LSHI (imm amount); memory: op 0100 ext 0000 LOAD, ext 0100 STOR.
REQ-029 EXEC register form: pcRegMuxEn=1, mux4En=0, aluControl per op, resultRegEn=1 except CMP.
REQ-030 EXEC immediate form: as REQ-029 with mux4En=1; signEn=1 for ADD/SUB/CMP/MOV, 0 for AND/OR/XOR.
REQ-031 EXEC shift: shiftALUMuxEn=1, signEn=1, regImmMuxEn=0 (LSH) or 1 (LSHI), resultRegEn=1.
REQ-032 EXEC -> WB, except CMP/CMPI -> FETCH.
REQ-033 MEM: memRead (LOAD) or memWrite (STOR) held until memReady; LOAD -> WB, STOR -> FETCH.
REQ-034 WB: regFileEn=1, regFileResultCont=1 for LOAD else 0; -> FETCH.
REQ-035 Wait counter clears on state entry and on memReady; increments each FETCH/MEM cycle with memReady=0.
REQ-036 Counter reaching WAIT_MAX with memReady=0: set memErr, drop request one cycle, go FETCH; memReady in that same cycle wins (normal completion, no error).
REQ-037 memReady ignored outside FETCH/MEM.
REQ-038 Zero-wait latency: ALU/shift 4 cycles, CMP 3, LOAD 4, STOR 3.

Reset
REQ-039 reset low, any state: state=FETCH, IR=0, counter=0, memErr=0, all outputs 0 immediately; in-flight instruction discarded, no writes.
REQ-040 First rising edge after reset high begins FETCH with memRead=1.

Verification
REQ-041 instruction 0x0351 (ADD R3,R1), memReady=1 -> states 0,1,2,4; EXEC aluControl=0, mux4En=0; WB regFileEn=1, regFileResultCont=0.
REQ-042 instruction 0x12FF (ANDI) -> EXEC signEn=0, mux4En=1, aluControl=2; 0x5205 (ADDI) -> signEn=1.
REQ-043 LOAD 0x4200, memReady low 3 cycles in MEM -> memRead held 4 cycles, then WB regFileResultCont=1.
REQ-044 memReady held low WAIT_MAX cycles in FETCH -> memErr=1, return to FETCH; memErr stays 1 until reset.
REQ-045 reset asserted mid-WB -> regFileEn=0 immediately, state=0, memErr=0.
REQ-046 instruction 0xB351 (CMP) -> resultRegEn=0, regFileEn never 1, back to FETCH after 3 cycles.

Source files
------------

// File: rtl/controller_if.sv
// Control bus between the multicycle controller (master) and its datapath/memory (slave).
interface controller_if;
  logic [15:0] instruction;
  logic        memReady;
  logic [3:0]  aluControl;
  logic        pcRegEn;
  logic        srcRegEn;
  logic        dstRegEn;
  logic        immRegEn;
  logic        resultRegEn;
  logic        regFileEn;
  logic        signEn;
  logic        pcRegMuxEn;
  logic [1:0]  mux4En;
  logic        shiftALUMuxEn;
  logic        regImmMuxEn;
  logic [1:0]  regFileResultCont;
  logic        memRead;
  logic        memWrite;
  logic        memErr;
  logic [2:0]  state;

  modport master (
    input  instruction, memReady,
    output aluControl, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
           regFileEn, signEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn,
           regFileResultCont, memRead, memWrite, memErr, state
  );

  modport slave (
    output instruction, memReady,
    input  aluControl, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
           regFileEn, signEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn,
           regFileResultCont, memRead, memWrite, memErr, state
  );
endinterface

// File: rtl/controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with memory-wait timeout.
// Control outputs are registered from the next state; only the PC-increment strobe follows memReady.
module controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic          clk,
  input logic          reset,
  controller_if.master bus
);
  localparam int unsigned   CW       = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);
  localparam logic [3:0]    C_CMP    = 4'b1011;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    K_ILL = 3'd0, K_REG = 3'd1, K_IMM = 3'd2, K_LSH = 3'd3,
    K_LSHI = 3'd4, K_LOAD = 3'd5, K_STOR = 3'd6
  } kind_e;

  function automatic logic in_set(input logic [3:0] c);
    case (c)
      4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: in_set = 1'b1;
      default: in_set = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] c);
    case (c)
      4'b0101: alu_of = 4'd0;
      4'b1001: alu_of = 4'd1;
      4'b0001: alu_of = 4'd2;
      4'b0010: alu_of = 4'd3;
      4'b0011: alu_of = 4'd4;
      4'b1011: alu_of = 4'd5;
      4'b1101: alu_of = 4'd6;
      default: alu_of = 4'd0;
    endcase
  endfunction

  // Arithmetic-style immediates are signed; logical ones are zero-extended.
  function automatic logic signed_imm(input logic [3:0] c);
    case (c)
      4'b0101, 4'b1001, 4'b1011, 4'b1101: signed_imm = 1'b1;
      default: signed_imm = 1'b0;
    endcase
  endfunction

  function automatic kind_e kind_of(input logic [15:0] w);
    if (w[15:12] == 4'b0000 && in_set(w[7:4]))          kind_of = K_REG;
    else if (in_set(w[15:12]))                          kind_of = K_IMM;
    else if (w[15:12] == 4'b1000 && w[7:4] == 4'b0100)  kind_of = K_LSH;
    else if (w[15:12] == 4'b1000 && w[7:4] == 4'b0000)  kind_of = K_LSHI;
    else if (w[15:12] == 4'b0100 && w[7:4] == 4'b0000)  kind_of = K_LOAD;
    else if (w[15:12] == 4'b0100 && w[7:4] == 4'b0100)  kind_of = K_STOR;
    else                                                kind_of = K_ILL;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  alu_q, alu_d;
  logic        src_q, src_d, dst_q, dst_d, imm_q, imm_d, res_q, res_d;
  logic        rf_q, rf_d, sign_q, sign_d, pcmux_q, pcmux_d;
  logic [1:0]  mux4_q, mux4_d, rfcont_q, rfcont_d;
  logic        shift_q, shift_d, regimm_q, regimm_d, rd_q, rd_d, wr_q, wr_d;

  kind_e       kind_s;
  logic [3:0]  code_s;
  logic        alu_form_s, req_s, abort_s, pc_inc_s;

  assign kind_s     = kind_of(ir_q);
  assign code_s     = (kind_s == K_REG) ? ir_q[7:4] : ir_q[15:12];
  assign alu_form_s = (kind_s == K_REG) || (kind_s == K_IMM);
  assign req_s      = rd_q | wr_q;
  assign pc_inc_s   = (state_q == FETCH) & rd_q & bus.memReady;

  // Next state, instruction latch, wait counter and sticky timeout flag.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    err_d   = err_q;
    abort_s = 1'b0;
    case (state_q)
      FETCH, MEM: begin
        if (!req_s) begin
          cnt_d = '0;
        end else if (bus.memReady) begin
          cnt_d = '0;
          if (state_q == FETCH) begin
            ir_d    = bus.instruction;
            state_d = DECODE;
          end else if (kind_s == K_LOAD) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end else if (cnt_q == WAIT_LIM) begin
          err_d   = 1'b1;
          abort_s = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        case (kind_s)
          K_REG, K_IMM, K_LSH, K_LSHI: state_d = EXEC;
          K_LOAD, K_STOR:              state_d = MEM;
          default:                     state_d = FETCH;
        endcase
      end
      EXEC:    state_d = (alu_form_s && code_s == C_CMP) ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Control outputs for the cycle about to start, derived from the next state.
  always_comb begin
    alu_d = 4'd0;  src_d = 1'b0;  dst_d = 1'b0;  imm_d = 1'b0;  res_d = 1'b0;
    rf_d = 1'b0;   sign_d = 1'b0; pcmux_d = 1'b0; mux4_d = 2'd0; rfcont_d = 2'd0;
    shift_d = 1'b0; regimm_d = 1'b0; rd_d = 1'b0; wr_d = 1'b0;
    case (state_d)
      FETCH:  rd_d = ~abort_s;
      DECODE: begin
        src_d = 1'b1;
        dst_d = 1'b1;
        imm_d = 1'b1;
      end
      EXEC: begin
        if (alu_form_s) begin
          pcmux_d = 1'b1;
          mux4_d  = (kind_s == K_IMM) ? 2'd1 : 2'd0;
          alu_d   = alu_of(code_s);
          res_d   = (code_s != C_CMP);
          sign_d  = (kind_s == K_IMM) && signed_imm(code_s);
        end else begin
          shift_d  = 1'b1;
          sign_d   = 1'b1;
          regimm_d = (kind_s == K_LSHI);
          res_d    = 1'b1;
        end
      end
      MEM: begin
        rd_d = (kind_s == K_LOAD);
        wr_d = (kind_s == K_STOR);
      end
      WB: begin
        rf_d     = 1'b1;
        rfcont_d = (kind_s == K_LOAD) ? 2'd1 : 2'd0;
      end
      default: rd_d = 1'b0;
    endcase
  end

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;     ir_q <= 16'd0;    cnt_q <= '0;       err_q <= 1'b0;
      alu_q <= 4'd0;        src_q <= 1'b0;    dst_q <= 1'b0;     imm_q <= 1'b0;
      res_q <= 1'b0;        rf_q <= 1'b0;     sign_q <= 1'b0;    pcmux_q <= 1'b0;
      mux4_q <= 2'd0;       rfcont_q <= 2'd0; shift_q <= 1'b0;   regimm_q <= 1'b0;
      rd_q <= 1'b0;         wr_q <= 1'b0;
    end else begin
      state_q <= state_d;   ir_q <= ir_d;     cnt_q <= cnt_d;    err_q <= err_d;
      alu_q <= alu_d;       src_q <= src_d;   dst_q <= dst_d;    imm_q <= imm_d;
      res_q <= res_d;       rf_q <= rf_d;     sign_q <= sign_d;  pcmux_q <= pcmux_d;
      mux4_q <= mux4_d;     rfcont_q <= rfcont_d; shift_q <= shift_d; regimm_q <= regimm_d;
      rd_q <= rd_d;         wr_q <= wr_d;
    end
  end

  // PC+1 uses the PC/const-1 ALU path, which is the all-zero select except for mux4En.
  assign bus.pcRegEn           = pc_inc_s;
  assign bus.mux4En            = mux4_q | (pc_inc_s ? 2'd2 : 2'd0);
  assign bus.aluControl        = alu_q;
  assign bus.srcRegEn          = src_q;
  assign bus.dstRegEn          = dst_q;
  assign bus.immRegEn          = imm_q;
  assign bus.resultRegEn       = res_q;
  assign bus.regFileEn         = rf_q;
  assign bus.signEn            = sign_q;
  assign bus.pcRegMuxEn        = pcmux_q;
  assign bus.shiftALUMuxEn     = shift_q;
  assign bus.regImmMuxEn       = regimm_q;
  assign bus.regFileResultCont = rfcont_q;
  assign bus.memRead           = rd_q;
  assign bus.memWrite          = wr_q;
  assign bus.memErr            = err_q;
  assign bus.state             = state_q;
endmodule
